// File: rtl/tour_pkg.sv
// Shared types and constants for the knight's tour sequencer.
// State encoding, tour opcode and default response count.
package tour_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LAUNCH = 3'd1,
      SOLVE  = 3'd2,
      PLAY   = 3'd3,
      FINISH = 3'd4
   } state_t;

   localparam logic [3:0] TOUR_OP = 4'h6;
   localparam int RESP_PER_TOUR_DEF = 48;

endpackage

// File: rtl/tour_wdog.sv
// Solve-phase watchdog: clears on launch, counts while solving,
// flags the last allowed cycle.
module tour_wdog #(
   parameter int TIMEOUT = 2000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int W = $clog2(TIMEOUT + 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign expire = en && (cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/tour_seq.sv
// Tour sequencer: intercepts tour commands, runs solve/play phases,
// and passes every other UART command straight through while idle.
module tour_seq
   import tour_pkg::*;
#(
   parameter int TIMEOUT       = 2000000,
   parameter int RESP_PER_TOUR = RESP_PER_TOUR_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] cmd_UART,
   input  logic        cmd_rdy_UART,
   output logic        clr_cmd_rdy_UART,
   output logic [15:0] cmd_fwd,
   output logic        cmd_rdy_fwd,
   input  logic        clr_cmd_rdy,
   output logic        go,
   output logic [2:0]  x_start,
   output logic [2:0]  y_start,
   input  logic        done,
   output logic        start_tour,
   input  logic        send_resp,
   output logic        busy,
   output logic        tour_done,
   output logic        tour_err
);

   state_t     state;
   logic [5:0] resp_cnt;
   logic       clr_q;
   logic       expire;
   logic       is_tour;
   logic       idle;

   assign is_tour = (cmd_UART[15:12] == TOUR_OP);
   assign idle    = (state == IDLE);
   assign busy    = !idle;
   assign cmd_fwd = cmd_UART;

   // Tour commands are never forwarded; their consume pulse is registered.
   assign cmd_rdy_fwd      = idle && cmd_rdy_UART && !is_tour;
   assign clr_cmd_rdy_UART = idle ? (clr_cmd_rdy && !is_tour) : clr_q;

   tour_wdog #(
      .TIMEOUT(TIMEOUT)
   ) u_wdog (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (state == LAUNCH),
      .en    (state == SOLVE),
      .expire(expire)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         resp_cnt   <= '0;
         x_start    <= '0;
         y_start    <= '0;
         go         <= 1'b0;
         start_tour <= 1'b0;
         tour_done  <= 1'b0;
         tour_err   <= 1'b0;
         clr_q      <= 1'b0;
      end else begin
         go         <= 1'b0;
         start_tour <= 1'b0;
         tour_done  <= 1'b0;
         clr_q      <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_rdy_UART && is_tour) begin
                  x_start  <= cmd_UART[6:4];
                  y_start  <= cmd_UART[2:0];
                  clr_q    <= 1'b1;
                  go       <= 1'b1;
                  tour_err <= 1'b0;
                  state    <= LAUNCH;
               end
            end
            LAUNCH: state <= SOLVE;
            SOLVE: begin
               // A late done still beats the watchdog on the same cycle.
               if (done) begin
                  start_tour <= 1'b1;
                  resp_cnt   <= '0;
                  state      <= PLAY;
               end else if (expire) begin
                  tour_err <= 1'b1;
                  state    <= IDLE;
               end
            end
            PLAY: begin
               if (send_resp) begin
                  if (resp_cnt == 6'(RESP_PER_TOUR - 1)) begin
                     tour_done <= 1'b1;
                     state     <= FINISH;
                  end else begin
                     resp_cnt <= resp_cnt + 6'd1;
                  end
               end
            end
            FINISH: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/tour_seq.md
TOUR_SEQ -- requirements
Module: tour_seq

Interface
REQ-001 Parameter TIMEOUT, default 2000000, maximum cycles SOLVE waits for done.
REQ-002 Parameter RESP_PER_TOUR, default 48, send_resp pulses per tour (24 moves x 2 commands).
REQ-003 clk  input  1  system clock; sole clock.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 cmd_UART  input  16  command from UART_wrapper.
REQ-006 cmd_rdy_UART  input  1  command valid from UART_wrapper.
REQ-007 clr_cmd_rdy_UART  output  1  consume/clear pulse to UART_wrapper.
REQ-008 cmd_fwd  output  16  command forwarded to TourCmd UART path.
REQ-009 cmd_rdy_fwd  output  1  forwarded command valid.
REQ-010 clr_cmd_rdy  input  1  clear from cmd_proc for forwarded command.
REQ-011 go  output  1  one-cycle start pulse to TourLogic.
REQ-012 x_start, y_start  output  3 each  latched start square to TourLogic.
REQ-013 done  input  1  TourLogic solution complete.
REQ-014 start_tour  output  1  one-cycle pulse to TourCmd.
REQ-015 send_resp  input  1  cmd_proc finished one command.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 tour_done  output  1  one-cycle pulse at tour completion.
REQ-018 tour_err  output  1  sticky timeout flag.

Function
REQ-019 Tour command: cmd_UART[15:12]==4'h6; x=cmd_UART[6:4], y=cmd_UART[2:0].
REQ-020 States IDLE, LAUNCH, SOLVE, PLAY, FINISH; encoding in package.
REQ-021 IDLE, cmd_rdy_UART high, tour opcode: latch x/y, pulse clr_cmd_rdy_UART one cycle, clear tour_err, go to LAUNCH next edge.
REQ-022 IDLE, non-tour command: cmd_fwd=cmd_UART and cmd_rdy_fwd=cmd_rdy_UART combinationally; clr_cmd_rdy_UART=clr_cmd_rdy.
REQ-023 Outside IDLE: cmd_rdy_fwd=0, clr_cmd_rdy_UART=0; UART command held pending, not lost.
REQ-024 LAUNCH: go=1 exactly one cycle, clear timeout counter, next state SOLVE.
REQ-025 SOLVE: counter increments each cycle; done -> PLAY; counter==TIMEOUT-1 without done -> set tour_err, IDLE.
REQ-026 done and timeout same cycle: done wins, no error.
REQ-027 PLAY entry: start_tour=1 exactly one cycle (first PLAY cycle); response counter cleared.
REQ-028 PLAY: each send_resp high cycle increments 6-bit response counter; at count RESP_PER_TOUR-1 plus send_resp -> FINISH.
REQ-029 send_resp outside PLAY ignored; done outside SOLVE ignored.
REQ-030 FINISH: tour_done=1 one cycle, next state IDLE.
REQ-031 go, start_tour, tour_done, clr_cmd_rdy_UART (tour consume) registered, glitch-free.
REQ-032 Latency: cmd accept -> go 1 cycle; done -> start_tour 1 cycle; last send_resp -> tour_done 1 cycle.

Reset
REQ-033 rst_n low: state IDLE, counters 0, x_start=y_start=0, go=start_tour=tour_done=tour_err=0, busy=0, cmd_rdy_fwd follows IDLE pass-through rule.
REQ-034 Reset mid-tour aborts immediately; no tour_done pulse; next tour requires new command.

Structure
REQ-035 Package tour_pkg: state enum, opcode constant TOUR_OP=4'h6, RESP_PER_TOUR default.
REQ-036 Single sub-module tour_wdog (timeout counter with clear/expire); remainder flat.

Verification
REQ-037 cmd_UART=16'h6023 ready in IDLE -> clr pulse, go next cycle, x_start=2, y_start=3, busy=1.
REQ-038 done 10 cycles after go -> start_tour one cycle later; 48 send_resp pulses -> tour_done one cycle after 48th, busy=0.
REQ-039 TIMEOUT=100, no done -> tour_err=1 at cycle 100 of SOLVE, IDLE, no start_tour.
REQ-040 cmd_UART=16'h2ABC in IDLE -> cmd_fwd=2ABC, cmd_rdy_fwd=1; during PLAY same command -> cmd_rdy_fwd=0 until IDLE.
REQ-041 rst_n low after 20 send_resp in PLAY -> all outputs reset value, no tour_done; new tour runs fully.
REQ-042 done on cycle TIMEOUT-1 -> PLAY entered, tour_err=0.
